// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_SPACE = 2'd2
  } fetch_state_e;

  localparam int          INST_BYTES       = 4;
  localparam int          BEAT_W           = 2;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: redirect input, byte memory port and decode handshake.
interface ifetch_if #(
  parameter int ADDR_W = 16
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_addr, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_addr, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/ifetch_unit_inst_queue.sv
// In-order instruction FIFO; synchronous flush wins over push and pop.
module inst_queue #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = store_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        store_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian words into a small queue for decode.
// Optional perf counters (perf_fetched, perf_stall) are built when IFETCH_PERF_EN is defined.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                QUEUE_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic        clk,
  input  logic        rst_n,
  ifetch_if.master    bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stall
`endif
);

  localparam int               CNT_W     = ((QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1) + 1;
  localparam int               ENTRY_W   = ADDR_W + 32;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(INST_BYTES - 1);

  fetch_state_e      state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [ADDR_W-1:0] fetch_pc_q, mem_addr_q, next_pc, redirect_tgt;
  logic              mem_req_q;

  logic              vld_p1;
  logic [BEAT_W-1:0] beat_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [23:0]       asm_p1;
  logic              rsp_done_p1;

  logic              q_push, q_pop, q_full, q_empty, space_ok;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    occ_next;
  logic [ENTRY_W-1:0] q_head;

  assign redirect_tgt = bus.redirect_addr & ~ADDR_W'(INST_BYTES - 1);
  assign next_pc      = fetch_pc_q + ADDR_W'(INST_BYTES);

  assign rsp_done_p1 = vld_p1 && (beat_p1 == LAST_BEAT) && !bus.redirect_valid;
  assign q_push      = rsp_done_p1 && !q_full;
  assign q_pop       = !q_empty && bus.inst_ready;

  // Occupancy seen by a beat-0 issued next cycle: queue after this edge plus any word still in flight.
  assign occ_next = {1'b0, q_count} + (CNT_W+1)'(q_push) - (CNT_W+1)'(q_pop)
                  + (CNT_W+1)'(mem_req_q);
  assign space_ok = (occ_next < (CNT_W+1)'(QUEUE_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (bus.redirect_valid) begin
      state_q    <= ISSUE;
      beat_q     <= '0;
      fetch_pc_q <= redirect_tgt;
      mem_req_q  <= 1'b1;
      mem_addr_q <= redirect_tgt;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= ISSUE;
          beat_q     <= '0;
          mem_req_q  <= 1'b1;
          mem_addr_q <= fetch_pc_q;
        end
        ISSUE: begin
          if (beat_q != LAST_BEAT) begin
            beat_q     <= beat_q + BEAT_W'(1);
            mem_addr_q <= {fetch_pc_q[ADDR_W-1:BEAT_W], beat_q + BEAT_W'(1)};
          end else begin
            beat_q     <= '0;
            fetch_pc_q <= next_pc;
            mem_addr_q <= next_pc;
            if (!space_ok) begin
              state_q   <= WAIT_SPACE;
              mem_req_q <= 1'b0;
            end
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            state_q   <= ISSUE;
            mem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: response tracker follows each request by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      beat_p1 <= '0;
    end else begin
      vld_p1  <= mem_req_q && !bus.redirect_valid;
      beat_p1 <= mem_addr_q[BEAT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_req_q) pc_p1 <= {mem_addr_q[ADDR_W-1:BEAT_W], BEAT_W'(0)};
    if (vld_p1) begin
      case (beat_p1)
        2'd0:    asm_p1[23:16] <= bus.mem_rdata;
        2'd1:    asm_p1[15:8]  <= bus.mem_rdata;
        2'd2:    asm_p1[7:0]   <= bus.mem_rdata;
        default: ;
      endcase
    end
  end

  inst_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (q_push),
    .push_data ({pc_p1, asm_p1, bus.mem_rdata}),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = !q_empty;
  assign bus.inst_data  = q_head[31:0];
  assign bus.inst_pc    = q_head[ENTRY_W-1:32];

`ifdef IFETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (q_push) perf_fetched <= sat_inc(perf_fetched);
      if (state_q == WAIT_SPACE) perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; memory returns the low address byte (mem[i] = i).
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic ovf_seen = 1'b0;

  always #5 clk = ~clk;

  ifetch_if #(.ADDR_W(16)) bus ();

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetched, perf_stall;
`endif

  ifetch_unit #(
    .ADDR_W      (16),
    .QUEUE_DEPTH (2),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial bus.mem_rdata = 8'h00;
  always @(posedge clk) if (bus.mem_req) bus.mem_rdata <= bus.mem_addr[7:0];

  always @(posedge clk) if (rst_n && dut.rsp_done_p1 && dut.q_full) ovf_seen <= 1'b1;

  task automatic tick_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = 16'h0000;
    bus.inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (bus.inst_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", bus.inst_valid); end
    compared++; if (bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
    compared++; if (bus.mem_addr !== 16'h0000) begin mismatched++; $display("FAIL rst_addr: got %h want 0000", bus.mem_addr); end
    compared++; if (bus.inst_data !== 32'h0) begin mismatched++; $display("FAIL rst_data: got %h want 0", bus.inst_data); end
    compared++; if (bus.inst_pc !== 16'h0000) begin mismatched++; $display("FAIL rst_pc: got %h want 0000", bus.inst_pc); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    bus.inst_ready = 1'b1;
    compared++; if (bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL c0_req: got %b want 0", bus.mem_req); end
    tick_to(1);
    compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin mismatched++; $display("FAIL c1_req: got %b/%h want 1/0000", bus.mem_req, bus.mem_addr); end
    tick_to(4);
    compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0003) begin mismatched++; $display("FAIL c4_req: got %b/%h want 1/0003", bus.mem_req, bus.mem_addr); end
    tick_to(5);
    compared++; if (bus.inst_valid !== 1'b0) begin mismatched++; $display("FAIL c5_valid: got %b want 0", bus.inst_valid); end
    tick_to(6);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000 || bus.inst_data !== 32'h00010203) begin mismatched++; $display("FAIL c6_inst: got %b/%h/%h want 1/0000/00010203", bus.inst_valid, bus.inst_pc, bus.inst_data); end
    tick_to(7);
    compared++; if (bus.inst_valid !== 1'b0) begin mismatched++; $display("FAIL c7_valid: got %b want 0", bus.inst_valid); end
    tick_to(10);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0004 || bus.inst_data !== 32'h04050607) begin mismatched++; $display("FAIL c10_inst: got %b/%h/%h want 1/0004/04050607", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.inst_ready = 1'b0;
    tick_to(6);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000) begin mismatched++; $display("FAIL bp_first: got %b/%h want 1/0000", bus.inst_valid, bus.inst_pc); end
    for (int c = 9; c <= 13; c++) begin
      tick_to(c);
      compared++; if (bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL bp_stall_req c%0d: got %b want 0", c, bus.mem_req); end
    end
    compared++; if (bus.inst_pc !== 16'h0000 || bus.inst_data !== 32'h00010203) begin mismatched++; $display("FAIL bp_hold: got %h/%h want 0000/00010203", bus.inst_pc, bus.inst_data); end
    tick_to(14);
    bus.inst_ready = 1'b1;
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000) begin mismatched++; $display("FAIL bp_pop0: got %b/%h want 1/0000", bus.inst_valid, bus.inst_pc); end
    tick_to(15);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0004 || bus.inst_data !== 32'h04050607) begin mismatched++; $display("FAIL bp_pop1: got %b/%h/%h want 1/0004/04050607", bus.inst_valid, bus.inst_pc, bus.inst_data); end
    compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0008) begin mismatched++; $display("FAIL bp_resume: got %b/%h want 1/0008", bus.mem_req, bus.mem_addr); end
`ifdef IFETCH_PERF_EN
    compared++; if (perf_fetched !== 16'd2) begin mismatched++; $display("FAIL perf_fetched: got %0d want 2", perf_fetched); end
    compared++; if (perf_stall !== 16'd6) begin mismatched++; $display("FAIL perf_stall: got %0d want 6", perf_stall); end
`endif
    for (int c = 16; c <= 19; c++) begin
      tick_to(c);
      compared++; if (bus.inst_valid !== 1'b0) begin mismatched++; $display("FAIL bp_gap c%0d: got %b want 0", c, bus.inst_valid); end
    end
    tick_to(20);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0008 || bus.inst_data !== 32'h08090A0B) begin mismatched++; $display("FAIL bp_third: got %b/%h/%h want 1/0008/08090a0b", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.inst_ready = 1'b1;
    tick_to(11);
    compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h000A) begin mismatched++; $display("FAIL rd_pre: got %b/%h want 1/000a", bus.mem_req, bus.mem_addr); end
    bus.redirect_addr = 16'h0020;
    bus.redirect_valid = 1'b1;
    tick_to(12);
    bus.redirect_valid = 1'b0;
    compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0020) begin mismatched++; $display("FAIL rd_req: got %b/%h want 1/0020", bus.mem_req, bus.mem_addr); end
    for (int c = 12; c <= 16; c++) begin
      tick_to(c);
      compared++; if (bus.inst_valid !== 1'b0) begin mismatched++; $display("FAIL rd_flush c%0d: got %b/%h want 0", c, bus.inst_valid, bus.inst_pc); end
    end
    tick_to(17);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0020 || bus.inst_data !== 32'h20212223) begin mismatched++; $display("FAIL rd_target: got %b/%h/%h want 1/0020/20212223", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [5];
    exp_addr[0] = 16'hFFFC; exp_addr[1] = 16'hFFFD; exp_addr[2] = 16'hFFFE;
    exp_addr[3] = 16'hFFFF; exp_addr[4] = 16'h0000;
    do_reset();
    bus.inst_ready = 1'b1;
    tick_to(3);
    bus.redirect_addr = 16'hFFFC;
    bus.redirect_valid = 1'b1;
    tick_to(4);
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick_to(4 + k);
      compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr[k]) begin mismatched++; $display("FAIL wrap_addr%0d: got %b/%h want 1/%h", k, bus.mem_req, bus.mem_addr, exp_addr[k]); end
    end
    tick_to(9);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'hFFFC || bus.inst_data !== 32'hFCFDFEFF) begin mismatched++; $display("FAIL wrap_inst0: got %b/%h/%h want 1/fffc/fcfdfeff", bus.inst_valid, bus.inst_pc, bus.inst_data); end
    tick_to(13);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000 || bus.inst_data !== 32'h00010203) begin mismatched++; $display("FAIL wrap_inst1: got %b/%h/%h want 1/0000/00010203", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_unaligned();
    do_reset();
    bus.inst_ready = 1'b1;
    tick_to(2);
    bus.redirect_addr = 16'h0013;
    bus.redirect_valid = 1'b1;
    tick_to(3);
    bus.redirect_valid = 1'b0;
    compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0010) begin mismatched++; $display("FAIL ua_addr: got %b/%h want 1/0010", bus.mem_req, bus.mem_addr); end
    tick_to(8);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0010 || bus.inst_data !== 32'h10111213) begin mismatched++; $display("FAIL ua_inst: got %b/%h/%h want 1/0010/10111213", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.inst_ready = 1'b0;
    tick_to(7);
    compared++; if (bus.inst_valid !== 1'b1 || bus.mem_req !== 1'b1) begin mismatched++; $display("FAIL ar_pre: got %b/%b want 1/1", bus.inst_valid, bus.mem_req); end
    rst_n = 1'b0;
    #1;
    compared++; if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL ar_drop: got %b/%b want 0/0", bus.inst_valid, bus.mem_req); end
    compared++; if (bus.inst_pc !== 16'h0000 || bus.inst_data !== 32'h0 || bus.mem_addr !== 16'h0000) begin mismatched++; $display("FAIL ar_vals: got %h/%h/%h want 0", bus.inst_pc, bus.inst_data, bus.mem_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
`ifdef IFETCH_PERF_EN
    compared++; if (perf_fetched !== 16'd0 || perf_stall !== 16'd0) begin mismatched++; $display("FAIL ar_perf: got %0d/%0d want 0/0", perf_fetched, perf_stall); end
`endif
    tick_to(1);
    compared++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin mismatched++; $display("FAIL ar_c1: got %b/%h want 1/0000", bus.mem_req, bus.mem_addr); end
    tick_to(5);
    compared++; if (bus.inst_valid !== 1'b0) begin mismatched++; $display("FAIL ar_c5: got %b want 0", bus.inst_valid); end
    tick_to(6);
    compared++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000 || bus.inst_data !== 32'h00010203) begin mismatched++; $display("FAIL ar_c6: got %b/%h/%h want 1/0000/00010203", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_no_overflow();
    compared++; if (ovf_seen !== 1'b0) begin mismatched++; $display("FAIL push_full: got %b want 0", ovf_seen); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_unaligned();
    test_async_reset();
    test_no_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
